fpu_op_controller: RTL and testbench
====================================

// Module: fpu_op_controller
// PURPOSE
//  Front-end sequencer for the divide/sqrt datapath. Accepts one IEEE754 request at a time over
//  valid/ready, registers operands, decodes them through an internal input_interface instance,
//  and returns a canned IEEE result for special operands (zero/inf/NaN). All other operands go to
//  the shared iterative unit via a start/done handshake, with a timeout watchdog.
//  Sits between the issue logic and the div/sqrt cores.
// PARAMETERS
//  TIMEOUT   256  max WAIT cycles after unit_start before abort; must be >= 2
//  CNT_W     9    watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   controller can accept (IDLE only)
//  req_a        in   64  operand A (single precision in [31:0], upper bits ignored)
//  req_b        in   64  operand B (divisor; ignored for sqrt)
//  req_op       in   2   [1]==`S_MODE -> single else double; [0]: 0=divide A/B, 1=sqrt A
//  resp_valid   out  1   result available
//  resp_ready   in   1   consumer takes result
//  resp_result  out  64  IEEE result; single mode -> [63:32]=0
//  resp_special out  1   result produced by fast path, unit not used
//  resp_timeout out  1   unit did not finish; result is canonical qNaN
//  unit_start   out  1   one-cycle start pulse to datapath
//  unit_op      out  2   registered req_op
//  unit_int_a/b out  53  integer significands (outA/outB of input_interface)
//  unit_exp_a/b out  11  biased exponents
//  unit_sign_a/b out 1   signs
//  unit_flags_a/b out 3  decode flags (000 denorm, 001 zero, 010 inf, 011 nan, 100 normal)
//  unit_done    in   1   datapath result valid (one cycle)
//  unit_result  in   64  datapath result
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1 in the cycle after reset release; resp_valid, resp_special,
//   resp_timeout, unit_start, busy = 0; resp_result=0; counter=0; operand regs=0.
//  FSM: IDLE -> DECODE -> (SPECIAL_RESP | ISSUE -> WAIT) -> RESP -> IDLE.
//  IDLE: req_ready=1; req_valid -> latch a/b/op, go DECODE. No other state accepts requests.
//  DECODE (1 cycle): flags from registered operands. Special -> RESP with resp_special=1:
//   div: NaN if A or B NaN, 0/0, inf/inf; inf (sA^sB) if B zero or A inf; zero (sA^sB) if
//        A zero or B inf; NaN checks take priority over inf/zero.
//   sqrt: NaN if A NaN or (sA=1 and A nonzero); +-0 -> same signed 0; +inf -> +inf.
//   Canonical qNaN: single 32'h7FC00000, double 64'h7FF8_0000_0000_0000; NaN sign=0.
//   Denormal/normal operands are not special -> ISSUE.
//  ISSUE (1 cycle): unit_start=1, counter cleared -> WAIT.
//  WAIT: counter++ per cycle; unit_done -> capture unit_result, RESP. If counter reaches
//   TIMEOUT-1 without done -> RESP with qNaN, resp_timeout=1. done on the TIMEOUT-1 cycle wins.
//  RESP: resp_valid=1 and result/flags held stable until resp_ready; on handshake -> IDLE,
//   resp_valid drops next cycle. No same-cycle re-accept (req_ready returns in IDLE).
//  unit_done outside WAIT is ignored (stale done after timeout or reset never produces a resp).
//  unit_* operand outputs stay stable from DECODE until the next accept.
//  Latency: accept at cycle 0 -> special resp_valid at cycle 2; unit_start at cycle 2;
//   done at cycle k -> resp_valid at k+1.
//  rst in any state: return to IDLE next edge, in-flight request dropped, no response.
// TESTING
//  1 double 6.0/2.0 (0x4018..0, 0x4000..0): unit_start at cycle 2, exp_a=0x401, int_a=0x18000000000000;
//    drive unit_done cycle 7 with 0x4008..0 -> resp_valid cycle 8, resp_special=0.
//  2 single sqrt of 0xBF800000 (-1.0) -> no unit_start, resp_result=0x7FC00000, resp_special=1, cycle 2.
//  3 double 1.0/+0 -> resp_result=0x7FF0000000000000; -0/-0 -> 0x7FF8000000000000; sqrt(-0) -> 0x8000000000000000.
//  4 TIMEOUT=8, no unit_done -> resp_timeout=1, qNaN; late unit_done ignored, next request clean.
//  5 hold resp_ready=0 for 5 cycles: result stable, req_ready=0, req_valid ignored; then release.
//  6 rst asserted in WAIT: next cycle busy=0, no resp_valid, subsequent done ignored.

Source files
------------

// File: rtl/fpu_op_controller.sv
// Front-end sequencer for the divide/sqrt datapath: latches one request, decodes the operands,
// answers zero/inf/NaN cases directly and hands everything else to the iterative unit with a watchdog.

module input_interface (
    input  logic        single,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [52:0] out_a,
    output logic [52:0] out_b,
    output logic [10:0] exp_a,
    output logic [10:0] exp_b,
    output logic        sign_a,
    output logic        sign_b,
    output logic [2:0]  flags_a,
    output logic [2:0]  flags_b
);

    // Packed as {sign, exponent, significand, flags}
    function automatic logic [67:0] decode(input logic [63:0] x, input logic sp);
        logic        s;
        logic [10:0] e;
        logic        e_zero;
        logic        e_ones;
        logic        f_zero;
        logic [52:0] m;
        logic [2:0]  fl;
        if (sp) begin
            s      = x[31];
            e      = {3'b000, x[30:23]};
            e_zero = (x[30:23] == 8'h00);
            e_ones = &x[30:23];
            f_zero = (x[22:0] == 23'd0);
            m      = {29'd0, ~e_zero, x[22:0]};
        end else begin
            s      = x[63];
            e      = x[62:52];
            e_zero = (x[62:52] == 11'h000);
            e_ones = &x[62:52];
            f_zero = (x[51:0] == 52'd0);
            m      = {~e_zero, x[51:0]};
        end
        if (e_zero)
            fl = f_zero ? 3'b001 : 3'b000;
        else if (e_ones)
            fl = f_zero ? 3'b010 : 3'b011;
        else
            fl = 3'b100;
        return {s, e, m, fl};
    endfunction

    always_comb begin
        {sign_a, exp_a, out_a, flags_a} = decode(a, single);
        {sign_b, exp_b, out_b, flags_b} = decode(b, single);
    end

endmodule

module fpu_op_controller #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [1:0]  req_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_result,
    output logic        resp_special,
    output logic        resp_timeout,
    output logic        unit_start,
    output logic [1:0]  unit_op,
    output logic [52:0] unit_int_a,
    output logic [52:0] unit_int_b,
    output logic [10:0] unit_exp_a,
    output logic [10:0] unit_exp_b,
    output logic        unit_sign_a,
    output logic        unit_sign_b,
    output logic [2:0]  unit_flags_a,
    output logic [2:0]  unit_flags_b,
    input  logic        unit_done,
    input  logic [63:0] unit_result,
    output logic        busy
);

    localparam logic S_MODE = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] FL_ZERO = 3'b001;
    localparam logic [2:0] FL_INF  = 3'b010;
    localparam logic [2:0] FL_NAN  = 3'b011;

    typedef enum logic [2:0] {IDLE, DECODE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic [63:0]       a_q;
    logic [63:0]       b_q;
    logic [1:0]        op_q;
    logic [CNT_W-1:0]  cnt;
    logic [63:0]       result_q;
    logic              special_q;
    logic              timeout_q;
    logic              single;
    logic              is_special;
    logic [63:0]       special_val;

    assign single  = (op_q[1] == S_MODE);
    assign unit_op = op_q;

    input_interface u_decode (
        .single  (single),
        .a       (a_q),
        .b       (b_q),
        .out_a   (unit_int_a),
        .out_b   (unit_int_b),
        .exp_a   (unit_exp_a),
        .exp_b   (unit_exp_b),
        .sign_a  (unit_sign_a),
        .sign_b  (unit_sign_b),
        .flags_a (unit_flags_a),
        .flags_b (unit_flags_b)
    );

    function automatic logic [63:0] qnan(input logic sp);
        return sp ? 64'h0000_0000_7FC0_0000 : 64'h7FF8_0000_0000_0000;
    endfunction

    function automatic logic [63:0] inf_val(input logic sp, input logic s);
        return sp ? {32'd0, s, 8'hFF, 23'd0} : {s, 11'h7FF, 52'd0};
    endfunction

    function automatic logic [63:0] zero_val(input logic sp, input logic s);
        return sp ? {32'd0, s, 31'd0} : {s, 63'd0};
    endfunction

    // Packed as {special, value}; NaN cases are tested before inf/zero
    function automatic logic [64:0] special_of(input logic sqrt, input logic sp,
                                               input logic sa, input logic sb,
                                               input logic [2:0] fa, input logic [2:0] fb);
        logic s;
        s = sa ^ sb;
        if (sqrt) begin
            if (fa == FL_NAN || (sa && fa != FL_ZERO)) return {1'b1, qnan(sp)};
            if (fa == FL_ZERO)                         return {1'b1, zero_val(sp, sa)};
            if (fa == FL_INF)                          return {1'b1, inf_val(sp, 1'b0)};
            return {1'b0, 64'd0};
        end
        if (fa == FL_NAN || fb == FL_NAN || (fa == FL_ZERO && fb == FL_ZERO) ||
            (fa == FL_INF && fb == FL_INF))            return {1'b1, qnan(sp)};
        if (fb == FL_ZERO || fa == FL_INF)             return {1'b1, inf_val(sp, s)};
        if (fa == FL_ZERO || fb == FL_INF)             return {1'b1, zero_val(sp, s)};
        return {1'b0, 64'd0};
    endfunction

    assign {is_special, special_val} = special_of(op_q[0], single, unit_sign_a, unit_sign_b,
                                                  unit_flags_a, unit_flags_b);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = DECODE;
            DECODE:  state_next = is_special ? RESP : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (unit_done || cnt == CNT_LAST) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state == IDLE);
        resp_valid   = (state == RESP);
        unit_start   = (state == ISSUE);
        busy         = (state != IDLE);
        resp_special = (state == RESP) && special_q;
        resp_timeout = (state == RESP) && timeout_q;
        resp_result  = result_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= 64'd0;
            b_q       <= 64'd0;
            op_q      <= 2'd0;
            cnt       <= '0;
            result_q  <= 64'd0;
            special_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                a_q  <= req_a;
                b_q  <= req_b;
                op_q <= req_op;
            end
            if (state == ISSUE) cnt <= '0;
            if (state == WAIT)  cnt <= cnt + CNT_W'(1);
            if (state == DECODE && is_special) begin
                result_q  <= special_val;
                special_q <= 1'b1;
                timeout_q <= 1'b0;
            end
            // A done arriving on the final watchdog cycle still counts as a real result
            if (state == WAIT) begin
                if (unit_done) begin
                    result_q  <= unit_result;
                    special_q <= 1'b0;
                    timeout_q <= 1'b0;
                end else if (cnt == CNT_LAST) begin
                    result_q  <= qnan(single);
                    special_q <= 1'b0;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_op_controller.sv
// Directed bench for fpu_op_controller: table of fast-path vectors plus hand-written
// sequences for the unit handshake, watchdog, back-pressure and reset cases.

module tb_fpu_op_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_a = 64'd0;
    logic [63:0] req_b = 64'd0;
    logic [1:0]  req_op = 2'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_result;
    logic        resp_special;
    logic        resp_timeout;
    logic        unit_start;
    logic [1:0]  unit_op;
    logic [52:0] unit_int_a;
    logic [52:0] unit_int_b;
    logic [10:0] unit_exp_a;
    logic [10:0] unit_exp_b;
    logic        unit_sign_a;
    logic        unit_sign_b;
    logic [2:0]  unit_flags_a;
    logic [2:0]  unit_flags_b;
    logic        unit_done = 1'b0;
    logic [63:0] unit_result = 64'd0;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fpu_op_controller #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_special (resp_special),
        .resp_timeout (resp_timeout),
        .unit_start   (unit_start),
        .unit_op      (unit_op),
        .unit_int_a   (unit_int_a),
        .unit_int_b   (unit_int_b),
        .unit_exp_a   (unit_exp_a),
        .unit_exp_b   (unit_exp_b),
        .unit_sign_a  (unit_sign_a),
        .unit_sign_b  (unit_sign_b),
        .unit_flags_a (unit_flags_a),
        .unit_flags_b (unit_flags_b),
        .unit_done    (unit_done),
        .unit_result  (unit_result),
        .busy         (busy)
    );

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in cycle 0 and returns one edge later, inside cycle 1
    task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        check("req_ready_accept", {63'd0, req_ready}, 64'd1);
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        check("resp_valid_drop", {63'd0, resp_valid}, 64'd0);
        check("req_ready_back", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        vecs[0]  = '{2'b11, 64'h0000_0000_BF80_0000, 64'd0, 64'h0000_0000_7FC0_0000};
        vecs[1]  = '{2'b00, 64'h3FF0_0000_0000_0000, 64'd0, 64'h7FF0_0000_0000_0000};
        vecs[2]  = '{2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h7FF8_0000_0000_0000};
        vecs[3]  = '{2'b01, 64'h8000_0000_0000_0000, 64'd0, 64'h8000_0000_0000_0000};
        vecs[4]  = '{2'b00, 64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000};
        vecs[5]  = '{2'b00, 64'hFFF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'hFFF0_0000_0000_0000};
        vecs[6]  = '{2'b00, 64'h4000_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000};
        vecs[7]  = '{2'b10, 64'h0000_0000_7F80_0001, 64'd0, 64'h0000_0000_7FC0_0000};
        vecs[8]  = '{2'b10, 64'd0, 64'h0000_0000_4040_0000, 64'd0};
        vecs[9]  = '{2'b11, 64'h0000_0000_7F80_0000, 64'd0, 64'h0000_0000_7F80_0000};
        vecs[10] = '{2'b01, 64'hFFF0_0000_0000_0000, 64'd0, 64'h7FF8_0000_0000_0000};
        vecs[11] = '{2'b10, 64'hDEAD_BEEF_BF80_0000, 64'd0, 64'h0000_0000_FF80_0000};
        vecs[12] = '{2'b00, 64'd0, 64'h7FF8_0000_0000_0001, 64'h7FF8_0000_0000_0000};

        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_unit_start", {63'd0, unit_start}, 64'd0);
        check("rst_resp_result", resp_result, 64'd0);
        check("rst_int_a", {11'd0, unit_int_a}, 64'd0);

        // Fast-path table: response two cycles after accept, unit never started
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_busy", i), {63'd0, busy}, 64'd1);
            check($sformatf("vec%0d_early", i), {63'd0, resp_valid}, 64'd0);
            cyc();
            check($sformatf("vec%0d_valid", i), {63'd0, resp_valid}, 64'd1);
            check($sformatf("vec%0d_special", i), {63'd0, resp_special}, 64'd1);
            check($sformatf("vec%0d_start", i), {63'd0, unit_start}, 64'd0);
            check($sformatf("vec%0d_result", i), resp_result, vecs[i].res);
            release_resp();
        end

        // Double 6.0 / 2.0 through the unit, done in cycle 7
        send(2'b00, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000);
        check("d_exp_a", {53'd0, unit_exp_a}, 64'h401);
        check("d_int_a", {11'd0, unit_int_a}, 64'h0018_0000_0000_0000);
        check("d_flags_a", {61'd0, unit_flags_a}, 64'd4);
        check("d_start_c1", {63'd0, unit_start}, 64'd0);
        cyc();
        check("d_start_c2", {63'd0, unit_start}, 64'd1);
        check("d_exp_b", {53'd0, unit_exp_b}, 64'h400);
        check("d_int_b", {11'd0, unit_int_b}, 64'h0010_0000_0000_0000);
        check("d_op", {62'd0, unit_op}, 64'd0);
        cyc();
        check("d_start_c3", {63'd0, unit_start}, 64'd0);
        repeat (4) cyc();
        check("d_valid_c7", {63'd0, resp_valid}, 64'd0);
        unit_done   = 1'b1;
        unit_result = 64'h4008_0000_0000_0000;
        cyc();
        unit_done = 1'b0;
        check("d_valid_c8", {63'd0, resp_valid}, 64'd1);
        check("d_special", {63'd0, resp_special}, 64'd0);
        check("d_timeout", {63'd0, resp_timeout}, 64'd0);
        check("d_result", resp_result, 64'h4008_0000_0000_0000);
        check("d_int_a_hold", {11'd0, unit_int_a}, 64'h0018_0000_0000_0000);
        release_resp();

        // Single sqrt 4.0, fast unit
        send(2'b11, 64'h0000_0000_4080_0000, 64'd0);
        check("s_exp_a", {53'd0, unit_exp_a}, 64'h081);
        check("s_int_a", {11'd0, unit_int_a}, 64'h80_0000);
        cyc();
        check("s_start", {63'd0, unit_start}, 64'd1);
        cyc();
        unit_done   = 1'b1;
        unit_result = 64'h0000_0000_4000_0000;
        cyc();
        unit_done = 1'b0;
        check("s_valid", {63'd0, resp_valid}, 64'd1);
        check("s_result", resp_result, 64'h0000_0000_4000_0000);
        release_resp();

        // Single denormal / 1.0 goes to the unit and times out
        send(2'b10, 64'h0000_0000_0000_0001, 64'h0000_0000_3F80_0000);
        check("t_flags_a", {61'd0, unit_flags_a}, 64'd0);
        check("t_int_a", {11'd0, unit_int_a}, 64'd1);
        check("t_flags_b", {61'd0, unit_flags_b}, 64'd4);
        cyc();
        check("t_start", {63'd0, unit_start}, 64'd1);
        repeat (8) cyc();
        check("t_valid_c10", {63'd0, resp_valid}, 64'd0);
        cyc();
        check("t_valid_c11", {63'd0, resp_valid}, 64'd1);
        check("t_timeout", {63'd0, resp_timeout}, 64'd1);
        check("t_special", {63'd0, resp_special}, 64'd0);
        check("t_result", resp_result, 64'h0000_0000_7FC0_0000);
        unit_done   = 1'b1;
        unit_result = 64'h1234_5678_9ABC_DEF0;
        cyc();
        unit_done = 1'b0;
        check("t_late_result", resp_result, 64'h0000_0000_7FC0_0000);
        release_resp();
        unit_done = 1'b1;
        cyc();
        unit_done = 1'b0;
        check("t_idle_done_valid", {63'd0, resp_valid}, 64'd0);
        check("t_idle_done_busy", {63'd0, busy}, 64'd0);
        cyc();
        check("t_idle_done_valid2", {63'd0, resp_valid}, 64'd0);
        send(2'b00, 64'h3FF0_0000_0000_0000, 64'd0);
        cyc();
        check("t_next_timeout", {63'd0, resp_timeout}, 64'd0);
        check("t_next_special", {63'd0, resp_special}, 64'd1);
        check("t_next_result", resp_result, 64'h7FF0_0000_0000_0000);
        release_resp();

        // Done on the last watchdog cycle beats the timeout
        send(2'b00, 64'h4008_0000_0000_0000, 64'h401C_0000_0000_0000);
        cyc();
        repeat (8) cyc();
        check("w_valid_c10", {63'd0, resp_valid}, 64'd0);
        unit_done   = 1'b1;
        unit_result = 64'h3FDB_6DB6_DB6D_B6DB;
        cyc();
        unit_done = 1'b0;
        check("w_valid", {63'd0, resp_valid}, 64'd1);
        check("w_timeout", {63'd0, resp_timeout}, 64'd0);
        check("w_result", resp_result, 64'h3FDB_6DB6_DB6D_B6DB);
        release_resp();

        // Back-pressure: response held, new requests refused
        send(2'b00, 64'h3FF0_0000_0000_0000, 64'd0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_valid", i), {63'd0, resp_valid}, 64'd1);
            check($sformatf("bp%0d_result", i), resp_result, 64'h7FF0_0000_0000_0000);
            check($sformatf("bp%0d_req_ready", i), {63'd0, req_ready}, 64'd0);
            req_valid = 1'b1;
            req_a     = 64'h8000_0000_0000_0000;
            req_b     = 64'h4000_0000_0000_0000;
            cyc();
        end
        req_valid = 1'b0;
        check("bp_exp_a_hold", {53'd0, unit_exp_a}, 64'h3FF);
        check("bp_valid_end", {63'd0, resp_valid}, 64'd1);
        release_resp();
        check("bp_busy_after", {63'd0, busy}, 64'd0);

        // Reset while waiting on the unit
        send(2'b00, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000);
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("r_busy", {63'd0, busy}, 64'd0);
        check("r_valid", {63'd0, resp_valid}, 64'd0);
        check("r_req_ready", {63'd0, req_ready}, 64'd1);
        check("r_result", resp_result, 64'd0);
        unit_done   = 1'b1;
        unit_result = 64'h4008_0000_0000_0000;
        cyc();
        unit_done = 1'b0;
        check("r_done_valid", {63'd0, resp_valid}, 64'd0);
        check("r_done_busy", {63'd0, busy}, 64'd0);
        cyc();
        check("r_done_valid2", {63'd0, resp_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
